// File: rtl/stream_demux_1xn.sv
// Packet-aware 1-to-N valid/ready stream demultiplexer with one registered output stage.
// The destination is locked on the first beat; packets addressed beyond N-1 are dropped and counted.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | between packets, next accepted beat is a first beat
//   FWD   | mid-packet, beats go to the locked destination dest_q
//   DROP  | mid-packet of a discarded packet, beats are swallowed
module stream_demux_1xn #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In,
    input  logic             In_valid,
    input  logic             In_last,
    output logic             In_ready,
    input  logic [SEL_W-1:0] Sel,
    output logic [WIDTH-1:0] Out,
    output logic             Out_last,
    output logic [N-1:0]     Out_valid,
    input  logic [N-1:0]     Out_ready,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [SEL_W:0]   N_EXT   = (SEL_W+1)'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   dest_q, dest_d;
    logic [SEL_W-1:0]   out_dest_q, out_dest_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [N-1:0]       out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               sel_bad;
    logic               held_rdy;
    logic               out_full;
    logic               drain;
    logic               accept;
    logic               load;
    logic [SEL_W-1:0]   load_dest;

    // Widened compare so the check stays well-formed when N is a power of two.
    assign sel_bad  = ({1'b0, Sel} >= N_EXT);
    assign out_full = |out_valid_q;
    assign drain    = out_full & held_rdy;
    assign accept   = In_valid & In_ready;

    // Only the ready of the channel owning the held beat matters.
    always_comb begin
        held_rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (out_dest_q == SEL_W'(i)) begin
                held_rdy = Out_ready[i];
            end
        end
    end

    always_comb begin
        In_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_DROP: In_ready = 1'b1;
                ST_IDLE: In_ready = sel_bad | !out_full | held_rdy;
                default: In_ready = !out_full | held_rdy;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        out_dest_d  = out_dest_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        drop_cnt_d  = drop_cnt_q;
        load        = 1'b0;
        load_dest   = dest_q;

        if (drain) begin
            out_valid_d = '0;
        end

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_bad) begin
                        if (drop_cnt_q != CNT_MAX) begin
                            drop_cnt_d = drop_cnt_q + 1'b1;
                        end
                        if (!In_last) begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        load      = 1'b1;
                        load_dest = Sel;
                        dest_d    = Sel;
                        if (!In_last) begin
                            state_d = ST_FWD;
                        end
                    end
                end
                ST_FWD: begin
                    load      = 1'b1;
                    load_dest = dest_q;
                    if (In_last) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (In_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A load in the same cycle as a drain overrides the clear above.
        if (load) begin
            out_data_d = In;
            out_last_d = In_last;
            out_dest_d = load_dest;
            for (int i = 0; i < N; i++) begin
                out_valid_d[i] = (load_dest == SEL_W'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dest_q      <= '0;
            out_dest_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            out_dest_q  <= out_dest_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign Out       = out_data_q;
    assign Out_last  = out_last_q;
    assign Out_valid = out_valid_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
